ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It is the consumer of the ID/EX register outputs.
- Applies operand forwarding, selects the ALU operation from alu_op/func and evaluates the ALU.
- Runs multi-cycle multiplies through a shift-add FSM that stalls the front end.
- Registers all results into the EX/MEM pipeline register, which is held inside this block.

Parameters:
- XLEN, 32, datapath width.
- MUL_STEPS, 32, shift-add iterations per multiply; equals XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill instruction in EX (branch/jump redirect)
- reg_dst_id_ex  in  1  1: dest=rd, 0: dest=rt
- reg_write_id_ex  in  1  register write enable
- alu_src_id_ex  in  1  1: operand B = signextend
- mem_read_id_ex  in  1  load
- mem_write_id_ex  in  1  store
- mem_to_reg_id_ex  in  1  writeback selects memory data
- branch_id_ex  in  1  beq
- jump_id_ex  in  1  jump
- alu_op_id_ex  in  2  ALU class
- signextend_id_ex  in  32  immediate
- func_id_ex  in  6  R-type function field
- rs_data_id_ex  in  32  rs register value
- rt_data_id_ex  in  32  rt register value
- rs_id_ex  in  5  rs index
- rt_id_ex  in  5  rt index
- rd_id_ex  in  5  rd index
- wb_reg_write  in  1  MEM/WB write enable
- wb_rd  in  5  MEM/WB destination
- wb_data  in  32  MEM/WB writeback value
- reg_write_ex_mem  out  1  registered control
- mem_read_ex_mem  out  1  registered control
- mem_write_ex_mem  out  1  registered control
- mem_to_reg_ex_mem  out  1  registered control
- jump_ex_mem  out  1  registered control
- branch_taken_ex_mem  out  1  branch & zero, registered
- zero_ex_mem  out  1  ALU result == 0, registered
- alu_result_ex_mem  out  32  ALU or multiply result
- store_data_ex_mem  out  32  forwarded rt value for stores
- write_reg_ex_mem  out  5  destination register index
- stall_ex  out  1  hold PC, IF/ID and ID/EX this cycle

Behaviour:
- Reset:
  - Synchronous active-high reset on clk, as already decided.
  - Every *_ex_mem output resets to 0.
  - FSM resets to IDLE; step counter and multiplier registers reset to 0.
  - stall_ex is 0 while in reset.
- Forwarding, applied independently to rs and rt:
  - First priority: reg_write_ex_mem && write_reg_ex_mem!=0 && write_reg_ex_mem==index selects alu_result_ex_mem.
  - Else: wb_reg_write && wb_rd!=0 && wb_rd==index selects wb_data.
  - Else: the ID/EX data.
- Operands:
  - A = forwarded rs.
  - B = alu_src ? signextend : forwarded rt.
  - store_data = forwarded rt.
- ALU select:
  - alu_op 00: add.
  - alu_op 01: sub.
  - alu_op 11: or (ori).
  - alu_op 10, decoded from func:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 101010 slt (signed, result 1 or 0)
    - 011000 mul (low 32 bits of the product)
    - any other func: result 0
- Arithmetic: add and sub wrap mod 2^32 with no overflow trap.
- Destination register: write_reg = reg_dst ? rd : rt.
- Non-multiply latency: 1 cycle. The EX/MEM register updates on every clk edge from the current ID/EX inputs.
- Multiply FSM, states IDLE, BUSY, DONE:
  - IDLE with a multiply present and no flush:
    - Latch forwarded A and B and clear the accumulator.
    - Set counter = MUL_STEPS-1 and go to BUSY.
  - BUSY: each cycle, add the multiplicand into the accumulator if the multiplier LSB is 1.
  - BUSY: each cycle, shift the multiplicand left and the multiplier right.
  - BUSY: when counter==0 go to DONE, else decrement the counter.
  - DONE:
    - stall_ex=0.
    - EX/MEM captures the accumulator with the multiply's controls and dest.
    - Next state IDLE.
  - stall_ex = (multiply present in ID/EX) && state!=DONE && !flush. It is combinational.
  - A multiply holds EX for exactly MUL_STEPS+2 cycles and asserts stall for MUL_STEPS+1 of them.
- While stall_ex=1:
  - EX/MEM captures a bubble: all control outputs 0, data outputs 0, write_reg 0.
  - Operands are not re-forwarded; the values latched at IDLE are used.
- Flush:
  - The EX/MEM capture is a bubble.
  - The FSM returns to IDLE from any state, aborting the multiply; stall_ex is 0.
  - Flush has priority over stall and over the DONE capture.
- rst has priority over flush.
- Reset mid-multiply: the FSM goes to IDLE, and outputs follow the reset values on the next edge.
- Back-to-back multiplies: after DONE, the FSM reaches IDLE one cycle later. The second multiply starts on that IDLE cycle.

Test Plan:
- Reset: assert rst for 2 cycles -> all *_ex_mem outputs = 0 and stall_ex = 0.
- EX/MEM forwarding: add r3=r1+r2 (5+7), then sub r4=r3-r1 with stale rs_data=0 -> alu_result_ex_mem 12, then 7.
- Priority: wb_rd=3 and wb_data=99 while EX/MEM also writes r3=12 -> EX/MEM value 12 is forwarded. With dest r0 on both, no forwarding occurs.
- Multiply timing: mul A=0xFFFF_FFFF, B=3 -> stall_ex high 33 cycles, bubbles in EX/MEM during the stall, then alu_result_ex_mem=0xFFFF_FFFD with reg_write=1.
- Multiply abort: flush at BUSY cycle 10 -> stall_ex drops that cycle, EX/MEM is a bubble, FSM is IDLE. A following add executes normally.
- Branch and slt:
  - beq with A=B=4 and branch=1 -> zero_ex_mem=1, branch_taken_ex_mem=1.
  - slt with A=-1, B=1 -> result 1.
  - lw with alu_src=1, A=100, imm=-4 -> result 96, write_reg=rt.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, shift-add multiplier FSM and the EX/MEM pipeline register.
// A multiply stalls the front end until its product is captured into EX/MEM.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            reg_dst_id_ex,
  input  logic            reg_write_id_ex,
  input  logic            alu_src_id_ex,
  input  logic            mem_read_id_ex,
  input  logic            mem_write_id_ex,
  input  logic            mem_to_reg_id_ex,
  input  logic            branch_id_ex,
  input  logic            jump_id_ex,
  input  logic [1:0]      alu_op_id_ex,
  input  logic [XLEN-1:0] signextend_id_ex,
  input  logic [5:0]      func_id_ex,
  input  logic [XLEN-1:0] rs_data_id_ex,
  input  logic [XLEN-1:0] rt_data_id_ex,
  input  logic [4:0]      rs_id_ex,
  input  logic [4:0]      rt_id_ex,
  input  logic [4:0]      rd_id_ex,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            reg_write_ex_mem,
  output logic            mem_read_ex_mem,
  output logic            mem_write_ex_mem,
  output logic            mem_to_reg_ex_mem,
  output logic            jump_ex_mem,
  output logic            branch_taken_ex_mem,
  output logic            zero_ex_mem,
  output logic [XLEN-1:0] alu_result_ex_mem,
  output logic [XLEN-1:0] store_data_ex_mem,
  output logic [4:0]      write_reg_ex_mem,
  output logic            stall_ex
);

  localparam int CNT_W = $clog2(MUL_STEPS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  mcand_r;
  logic [XLEN-1:0]  mplier_r;
  logic [XLEN-1:0]  acc_r;

  logic [XLEN-1:0]  fwd_a_s;
  logic [XLEN-1:0]  fwd_b_s;
  logic [XLEN-1:0]  op_b_s;
  logic [XLEN-1:0]  alu_res_s;
  logic [4:0]       dest_s;
  logic             is_mul_s;

  // The in-flight EX/MEM result wins over the older MEM/WB value; r0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] id_data,
    input logic            em_we,
    input logic [4:0]      em_rd,
    input logic [XLEN-1:0] em_data,
    input logic            wb_we,
    input logic [4:0]      wb_idx,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] r;
    if (em_we && (em_rd != 5'd0) && (em_rd == idx)) begin
      r = em_data;
    end else if (wb_we && (wb_idx != 5'd0) && (wb_idx == idx)) begin
      r = wb_val;
    end else begin
      r = id_data;
    end
    return r;
  endfunction

  // Operand selection and ALU evaluation
  always_comb begin
    fwd_a_s = fwd_sel(rs_id_ex, rs_data_id_ex, reg_write_ex_mem, write_reg_ex_mem,
                      alu_result_ex_mem, wb_reg_write, wb_rd, wb_data);
    fwd_b_s = fwd_sel(rt_id_ex, rt_data_id_ex, reg_write_ex_mem, write_reg_ex_mem,
                      alu_result_ex_mem, wb_reg_write, wb_rd, wb_data);
    op_b_s   = alu_src_id_ex ? signextend_id_ex : fwd_b_s;
    dest_s   = reg_dst_id_ex ? rd_id_ex : rt_id_ex;
    is_mul_s = (alu_op_id_ex == 2'b10) && (func_id_ex == FN_MUL);
    alu_res_s = '0;
    case (alu_op_id_ex)
      2'b00:   alu_res_s = fwd_a_s + op_b_s;
      2'b01:   alu_res_s = fwd_a_s - op_b_s;
      2'b11:   alu_res_s = fwd_a_s | op_b_s;
      2'b10: begin
        case (func_id_ex)
          FN_ADD:  alu_res_s = fwd_a_s + op_b_s;
          FN_SUB:  alu_res_s = fwd_a_s - op_b_s;
          FN_AND:  alu_res_s = fwd_a_s & op_b_s;
          FN_OR:   alu_res_s = fwd_a_s | op_b_s;
          FN_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
          FN_MUL:  alu_res_s = acc_r;
          default: alu_res_s = '0;
        endcase
      end
      default: alu_res_s = '0;
    endcase
  end

  assign stall_ex = is_mul_s && (state_r != ST_DONE) && !flush && !rst;

  // Shift-add multiplier sequencing; operands are latched once on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            mcand_r  <= fwd_a_s;
            mplier_r <= op_b_s;
            acc_r    <= '0;
            cnt_r    <= CNT_W'(MUL_STEPS - 1);
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (cnt_r == '0) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register; reset, flush and stall all load a bubble
  always_ff @(posedge clk) begin
    if (rst || flush || stall_ex) begin
      reg_write_ex_mem    <= 1'b0;
      mem_read_ex_mem     <= 1'b0;
      mem_write_ex_mem    <= 1'b0;
      mem_to_reg_ex_mem   <= 1'b0;
      jump_ex_mem         <= 1'b0;
      branch_taken_ex_mem <= 1'b0;
      zero_ex_mem         <= 1'b0;
      alu_result_ex_mem   <= '0;
      store_data_ex_mem   <= '0;
      write_reg_ex_mem    <= 5'd0;
    end else begin
      reg_write_ex_mem    <= reg_write_id_ex;
      mem_read_ex_mem     <= mem_read_id_ex;
      mem_write_ex_mem    <= mem_write_id_ex;
      mem_to_reg_ex_mem   <= mem_to_reg_id_ex;
      jump_ex_mem         <= jump_id_ex;
      branch_taken_ex_mem <= branch_id_ex && (alu_res_s == '0);
      zero_ex_mem         <= (alu_res_s == '0);
      alu_result_ex_mem   <= alu_res_s;
      store_data_ex_mem   <= fwd_b_s;
      write_reg_ex_mem    <= dest_s;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table for single-cycle ops plus hand-written multiply,
// abort and reset sequences, checked through an expected-output queue.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        reg_dst_id_ex, reg_write_id_ex, alu_src_id_ex, mem_read_id_ex;
  logic        mem_write_id_ex, mem_to_reg_id_ex, branch_id_ex, jump_id_ex;
  logic [1:0]  alu_op_id_ex;
  logic [31:0] signextend_id_ex;
  logic [5:0]  func_id_ex;
  logic [31:0] rs_data_id_ex, rt_data_id_ex;
  logic [4:0]  rs_id_ex, rt_id_ex, rd_id_ex;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        reg_write_ex_mem, mem_read_ex_mem, mem_write_ex_mem, mem_to_reg_ex_mem;
  logic        jump_ex_mem, branch_taken_ex_mem, zero_ex_mem;
  logic [31:0] alu_result_ex_mem, store_data_ex_mem;
  logic [4:0]  write_reg_ex_mem;
  logic        stall_ex;

  int n_cmp = 0;
  int n_bad = 0;
  logic [75:0] exp_q[$];

  // ctrl = {flush, reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump}
  localparam logic [8:0] C_R    = 9'b011000000;
  localparam logic [8:0] C_SW   = 9'b000101000;
  localparam logic [8:0] C_BEQ  = 9'b000000010;
  localparam logic [8:0] C_LW   = 9'b001110100;
  localparam logic [8:0] C_ORI  = 9'b001100000;
  localparam logic [8:0] C_J    = 9'b000000001;
  localparam logic [8:0] C_FL   = 9'b111000000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MUL  = 6'b011000;
  // expected ctrl = {reg_write, mem_read, mem_write, mem_to_reg, jump, branch_taken, zero}
  localparam logic [6:0] E_W    = 7'b1000000;
  localparam logic [6:0] E_WZ   = 7'b1000001;

  typedef struct {
    string       nm;
    logic [8:0]  ctrl;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] imm, a, b;
    logic [4:0]  rs, rt, rd;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic [6:0]  ec;
    logic [31:0] eres, esd;
    logic [4:0]  ewr;
  } vec_t;

  vec_t tbl[$];

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .reg_dst_id_ex(reg_dst_id_ex), .reg_write_id_ex(reg_write_id_ex),
    .alu_src_id_ex(alu_src_id_ex), .mem_read_id_ex(mem_read_id_ex),
    .mem_write_id_ex(mem_write_id_ex), .mem_to_reg_id_ex(mem_to_reg_id_ex),
    .branch_id_ex(branch_id_ex), .jump_id_ex(jump_id_ex),
    .alu_op_id_ex(alu_op_id_ex), .signextend_id_ex(signextend_id_ex),
    .func_id_ex(func_id_ex), .rs_data_id_ex(rs_data_id_ex), .rt_data_id_ex(rt_data_id_ex),
    .rs_id_ex(rs_id_ex), .rt_id_ex(rt_id_ex), .rd_id_ex(rd_id_ex),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .reg_write_ex_mem(reg_write_ex_mem), .mem_read_ex_mem(mem_read_ex_mem),
    .mem_write_ex_mem(mem_write_ex_mem), .mem_to_reg_ex_mem(mem_to_reg_ex_mem),
    .jump_ex_mem(jump_ex_mem), .branch_taken_ex_mem(branch_taken_ex_mem),
    .zero_ex_mem(zero_ex_mem), .alu_result_ex_mem(alu_result_ex_mem),
    .store_data_ex_mem(store_data_ex_mem), .write_reg_ex_mem(write_reg_ex_mem),
    .stall_ex(stall_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic [8:0] c, input logic [1:0] op,
                              input logic [5:0] fn, input logic [31:0] imm, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic wbe, input logic [4:0] wbr,
                              input logic [31:0] wbd, input logic [6:0] ec, input logic [31:0] eres,
                              input logic [31:0] esd, input logic [4:0] ewr);
    vec_t v;
    v.nm = nm; v.ctrl = c; v.op = op; v.fn = fn; v.imm = imm; v.a = a; v.b = b;
    v.rs = rs; v.rt = rt; v.rd = rd; v.wbe = wbe; v.wbr = wbr; v.wbd = wbd;
    v.ec = ec; v.eres = eres; v.esd = esd; v.ewr = ewr;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    {flush, reg_dst_id_ex, reg_write_id_ex, alu_src_id_ex, mem_read_id_ex,
     mem_write_id_ex, mem_to_reg_id_ex, branch_id_ex, jump_id_ex} = v.ctrl;
    alu_op_id_ex = v.op; func_id_ex = v.fn; signextend_id_ex = v.imm;
    rs_data_id_ex = v.a; rt_data_id_ex = v.b;
    rs_id_ex = v.rs; rt_id_ex = v.rt; rd_id_ex = v.rd;
    wb_reg_write = v.wbe; wb_rd = v.wbr; wb_data = v.wbd;
  endtask

  // One clock: check stall before the edge, queue the expected EX/MEM value, compare after it.
  task automatic cycle(input string nm, input logic [75:0] exp, input logic exp_stall);
    logic [75:0] got;
    logic [75:0] e;
    #2;
    n_cmp++;
    if (stall_ex !== exp_stall) begin
      n_bad++;
      $display("FAIL %s stall_ex: got %b expected %b", nm, stall_ex, exp_stall);
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got = {reg_write_ex_mem, mem_read_ex_mem, mem_write_ex_mem, mem_to_reg_ex_mem,
           jump_ex_mem, branch_taken_ex_mem, zero_ex_mem,
           alu_result_ex_mem, store_data_ex_mem, write_reg_ex_mem};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s ex_mem {ctrl,res,sd,wr}: got %h expected %h", nm, got, e);
    end
  endtask

  task automatic mul_run(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input int stalls, input logic [31:0] eres);
    apply(mk(nm, C_R, 2'b10, F_MUL, 32'd0, a, b, rs, rt, rd, 1'b0, 5'd0, 32'd0,
             7'd0, 32'd0, 32'd0, 5'd0));
    for (int i = 0; i < stalls; i++) cycle({nm, " stall"}, 76'd0, 1'b1);
    cycle({nm, " done"}, {E_W, eres, b, rd}, 1'b0);
  endtask

  initial begin
    tbl.push_back(mk("add fwd src", C_R, 2'b10, F_ADD, 32'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, E_W, 32'd12, 32'd7, 5'd3));
    tbl.push_back(mk("sub exmem fwd", C_R, 2'b10, F_SUB, 32'd0, 32'd0, 32'd5, 5'd3, 5'd1, 5'd4, 1'b0, 5'd0, 32'd0, E_W, 32'd7, 32'd5, 5'd4));
    tbl.push_back(mk("add r3 again", C_R, 2'b10, F_ADD, 32'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, E_W, 32'd12, 32'd7, 5'd3));
    tbl.push_back(mk("exmem over wb", C_R, 2'b10, F_ADD, 32'd0, 32'd0, 32'd0, 5'd3, 5'd0, 5'd5, 1'b1, 5'd3, 32'd99, E_W, 32'd12, 32'd0, 5'd5));
    tbl.push_back(mk("wb fwd", C_R, 2'b10, F_ADD, 32'd0, 32'd1, 32'd2, 5'd7, 5'd8, 5'd6, 1'b1, 5'd7, 32'd40, E_W, 32'd42, 32'd2, 5'd6));
    tbl.push_back(mk("write r0", C_R, 2'b10, F_ADD, 32'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 32'd0, E_W, 32'd12, 32'd7, 5'd0));
    tbl.push_back(mk("no fwd r0", C_R, 2'b10, F_ADD, 32'd0, 32'd3, 32'd4, 5'd0, 5'd0, 5'd9, 1'b1, 5'd0, 32'd99, E_W, 32'd7, 32'd4, 5'd9));
    tbl.push_back(mk("sw rt fwd", C_SW, 2'b00, 6'd0, 32'd8, 32'd100, 32'd0, 5'd1, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 7'b0010000, 32'd108, 32'd7, 5'd9));
    tbl.push_back(mk("beq taken", C_BEQ, 2'b01, 6'd0, 32'd0, 32'd4, 32'd4, 5'd10, 5'd11, 5'd0, 1'b0, 5'd0, 32'd0, 7'b0000011, 32'd0, 32'd4, 5'd11));
    tbl.push_back(mk("beq not taken", C_BEQ, 2'b01, 6'd0, 32'd0, 32'd4, 32'd5, 5'd10, 5'd11, 5'd0, 1'b0, 5'd0, 32'd0, 7'b0000000, 32'hFFFF_FFFF, 32'd5, 5'd11));
    tbl.push_back(mk("slt -1<1", C_R, 2'b10, F_SLT, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd12, 5'd13, 5'd14, 1'b0, 5'd0, 32'd0, E_W, 32'd1, 32'd1, 5'd14));
    tbl.push_back(mk("slt 1<-1", C_R, 2'b10, F_SLT, 32'd0, 32'd1, 32'hFFFF_FFFF, 5'd16, 5'd17, 5'd15, 1'b0, 5'd0, 32'd0, E_WZ, 32'd0, 32'hFFFF_FFFF, 5'd15));
    tbl.push_back(mk("lw", C_LW, 2'b00, 6'd0, 32'hFFFF_FFFC, 32'd100, 32'd55, 5'd20, 5'd21, 5'd0, 1'b0, 5'd0, 32'd0, 7'b1101000, 32'd96, 32'd55, 5'd21));
    tbl.push_back(mk("and", C_R, 2'b10, F_AND, 32'd0, 32'h0000_F0F0, 32'h0000_FF00, 5'd23, 5'd24, 5'd22, 1'b0, 5'd0, 32'd0, E_W, 32'h0000_F000, 32'h0000_FF00, 5'd22));
    tbl.push_back(mk("or", C_R, 2'b10, F_OR, 32'd0, 32'h0000_F0F0, 32'h0000_FF00, 5'd25, 5'd26, 5'd27, 1'b0, 5'd0, 32'd0, E_W, 32'h0000_FFF0, 32'h0000_FF00, 5'd27));
    tbl.push_back(mk("ori", C_ORI, 2'b11, 6'd0, 32'h0000_000F, 32'h0000_00F0, 32'd0, 5'd28, 5'd29, 5'd0, 1'b0, 5'd0, 32'd0, E_W, 32'h0000_00FF, 32'd0, 5'd29));
    tbl.push_back(mk("bad func", C_R, 2'b10, 6'b000000, 32'd0, 32'd5, 32'd6, 5'd30, 5'd31, 5'd1, 1'b0, 5'd0, 32'd0, E_WZ, 32'd0, 32'd6, 5'd1));
    tbl.push_back(mk("add wrap", C_R, 2'b10, F_ADD, 32'd0, 32'hFFFF_FFFF, 32'd2, 5'd2, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, E_W, 32'd1, 32'd2, 5'd4));
    tbl.push_back(mk("jump", C_J, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd6, 5'd0, 1'b0, 5'd0, 32'd0, 7'b0000101, 32'd0, 32'd0, 5'd6));
    tbl.push_back(mk("flush add", C_FL, 2'b10, F_ADD, 32'd0, 32'd1, 32'd1, 5'd7, 5'd8, 5'd9, 1'b0, 5'd0, 32'd0, 7'd0, 32'd0, 32'd0, 5'd0));

    // Reset with a multiply waiting in ID/EX: stall must stay low.
    rst = 1'b1;
    apply(mk("rst", C_R, 2'b10, F_MUL, 32'd0, 32'd2, 32'd3, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, 7'd0, 32'd0, 32'd0, 5'd0));
    cycle("reset 1", 76'd0, 1'b0);
    cycle("reset 2", 76'd0, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      cycle(tbl[i].nm, {tbl[i].ec, tbl[i].eres, tbl[i].esd, tbl[i].ewr}, 1'b0);
    end

    mul_run("mul ffffffff*3", 32'hFFFF_FFFF, 32'd3, 5'd1, 5'd2, 5'd10, 33, 32'hFFFF_FFFD);
    // Back-to-back: rs=r10 is forwarded from the first product on the IDLE cycle only.
    mul_run("mul fwd b2b", 32'd0, 32'd7, 5'd10, 5'd12, 5'd13, 33, 32'hFFFF_FFEB);

    apply(mk("abort", C_R, 2'b10, F_MUL, 32'd0, 32'd5, 32'd5, 5'd14, 5'd15, 5'd16, 1'b0, 5'd0, 32'd0, 7'd0, 32'd0, 32'd0, 5'd0));
    for (int i = 0; i < 11; i++) cycle("abort pre", 76'd0, 1'b1);
    flush = 1'b1;
    cycle("abort flush", 76'd0, 1'b0);
    apply(mk("add after abort", C_R, 2'b10, F_ADD, 32'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, 7'd0, 32'd0, 32'd0, 5'd0));
    cycle("add after abort", {E_W, 32'd12, 32'd7, 5'd3}, 1'b0);
    mul_run("mul after abort", 32'd5, 32'd5, 5'd14, 5'd15, 5'd16, 33, 32'd25);

    apply(mk("rst mid", C_R, 2'b10, F_MUL, 32'd0, 32'd2, 32'd2, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, 7'd0, 32'd0, 32'd0, 5'd0));
    for (int i = 0; i < 5; i++) cycle("rst mid pre", 76'd0, 1'b1);
    rst = 1'b1;
    cycle("rst mid", 76'd0, 1'b0);
    rst = 1'b0;
    apply(mk("add after rst", C_R, 2'b10, F_ADD, 32'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, 7'd0, 32'd0, 32'd0, 5'd0));
    cycle("add after rst", {E_W, 32'd12, 32'd7, 5'd3}, 1'b0);
    mul_run("mul after rst", 32'd2, 32'd3, 5'd1, 5'd2, 5'd3, 33, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
